// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory with programmable wait states for a
// small CPU, plus a host program-load port that streams words in sequentially.
//
// Build option: define MEM_RESP_PARITY_EN to store an even-parity bit with each
// word. Reads that find a bad parity bit pulse parity_err alongside ack and set
// the sticky err flag. Without the macro there is no parity storage and no
// parity_err port.
//
// Handshake: req is only looked at while the responder is idle (busy=0). When
// it is seen, addr/we/wdata are captured on that edge and later changes are
// ignored. Exactly WAIT_CYC+1 cycles later ack is high for one cycle, with
// rdata valid in that cycle. The next request can be sampled in the cycle after
// ack. The load port (ld_en/ld_valid/ld_data) takes priority over req in idle.
// Once in load mode, every cycle with ld_valid=1 stores one word; a CPU req in
// load mode is dropped and flagged on err.
module mem_responder #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  input  logic              ld_en,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] ld_cnt,
  output logic              err,
`ifdef MEM_RESP_PARITY_EN
  output logic              parity_err,
`endif
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_RESP_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        wait_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] ld_cnt_q;
  logic              err_q;

  // Decoded actions for the current cycle, produced by the FSM.
  logic              accept;
  logic              ld_start;
  logic              ld_wr;
  logic              cpu_wr;
  logic              load_req_err;
  logic              in_wait;
  logic              in_resp;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] resp_data;
  logic              parity_bad;

  // Stored word format: the data, plus a leading even-parity bit when enabled.
  function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef MEM_RESP_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // FSM state register; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle actions. Load mode beats a CPU request in idle.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    ld_start     = 1'b0;
    ld_wr        = 1'b0;
    cpu_wr       = 1'b0;
    load_req_err = 1'b0;
    in_wait      = 1'b0;
    in_resp      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_en) begin
          ld_start = 1'b1;
          state_d  = S_LOAD;
        end else if (req) begin
          accept  = 1'b1;
          state_d = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        in_wait = 1'b1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        in_resp = 1'b1;
        cpu_wr  = we_q;
        state_d = S_IDLE;
      end
      S_LOAD: begin
        ld_wr        = ld_valid;
        load_req_err = req;
        if (!ld_en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
    end else if (accept) begin
      addr_q     <= addr;
      we_q       <= we;
      wdata_q    <= wdata;
      wait_cnt_q <= WAIT_INIT;
    end else if (in_wait) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end

  // Load pointer: cleared on entry to load mode, wraps through the whole array.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ld_cnt_q <= '0;
    end else if (ld_start) begin
      ld_cnt_q <= '0;
    end else if (ld_wr) begin
      ld_cnt_q <= ld_cnt_q + ADDR_W'(1);
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      mem[addr_q] <= encode(wdata_q);
    end else if (ld_wr) begin
      mem[ld_cnt_q] <= encode(ld_data);
    end
  end

  assign rd_word   = mem[addr_q];
  // A write echoes its own data; a read returns the stored word.
  assign resp_data = we_q ? wdata_q : rd_word[DATA_W-1:0];

`ifdef MEM_RESP_PARITY_EN
  assign parity_bad = in_resp && !we_q && (^rd_word);
  assign parity_err = parity_bad;
`else
  assign parity_bad = 1'b0;
`endif

  // Remember the last response so rdata holds steady between acks.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rdata_q <= '0;
    end else if (in_resp) begin
      rdata_q <= resp_data;
    end
  end

  // Sticky error: CPU request during load, or a parity failure on a read.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_q <= 1'b0;
    end else if (load_req_err || parity_bad) begin
      err_q <= 1'b1;
    end
  end

  assign rdata     = in_resp ? resp_data : rdata_q;
  assign ack       = in_resp;
  assign busy      = (state_q != S_IDLE);
  assign ld_cnt    = ld_cnt_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized traffic on the CPU and load ports, with a
// transaction-level model that predicts ack/busy/rdata/err/ld_cnt every cycle.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_ = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              ld_en = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [ADDR_W-1:0] ld_cnt;
  logic              err;
  logic [1:0]        state_dbg;
`ifdef MEM_RESP_PARITY_EN
  logic              parity_err;
`endif

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_(rst_), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .ld_en(ld_en), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_cnt(ld_cnt), .err(err),
`ifdef MEM_RESP_PARITY_EN
    .parity_err(parity_err),
`endif
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                due;
    bit                w;
    int                a;
    logic [DATA_W-1:0] d;
    bit                ok;
    bit                perr;
  } txn_t;

  logic [DATA_W-1:0] exp_mem [DEPTH];
  bit                known   [DEPTH];
  bit                corrupt [DEPTH];
  txn_t              pend_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_load = 1'b0;
  bit                m_err = 1'b0;
  int                m_ptr = 0;
  logic [DATA_W-1:0] m_last = '0;
  bit                m_last_ok = 1'b1;
  int                cyc = 0;
  bit                acking;
  txn_t              t;
  logic [DATA_W-1:0] dexp;

  // Scoreboard: compare this cycle's outputs, then advance the model with the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    if (!rst_) begin
      pend_q.delete();
      exp_q.delete();
      m_load = 1'b0; m_err = 1'b0; m_ptr = 0; m_last = '0; m_last_ok = 1'b1;
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_ld_cnt", 32'(ld_cnt), 0);
    end else begin
      acking = (pend_q.size() != 0) && (pend_q[0].due == cyc);
      chk("ack", 32'(ack), 32'(acking));
      chk("busy", 32'(busy), 32'((pend_q.size() != 0) || m_load));
      chk("err", 32'(err), 32'(m_err));
      chk("ld_cnt", 32'(ld_cnt), 32'(m_ptr));
`ifdef MEM_RESP_PARITY_EN
      chk("parity_err", 32'(parity_err), 32'(acking && pend_q[0].perr));
`endif
      if (acking) begin
        if (pend_q[0].ok) chk("rdata_ack", 32'(rdata), 32'(exp_q[0]));
      end else if (m_last_ok) begin
        chk("rdata_hold", 32'(rdata), 32'(m_last));
      end
      if (acking) begin
        t    = pend_q.pop_front();
        dexp = exp_q.pop_front();
        if (t.w) begin
          exp_mem[t.a] = t.d; known[t.a] = 1'b1; corrupt[t.a] = 1'b0;
        end
        if (t.perr) m_err = 1'b1;
        m_last = dexp; m_last_ok = t.ok;
      end else if (m_load) begin
        if (ld_valid) begin
          exp_mem[m_ptr] = ld_data; known[m_ptr] = 1'b1; corrupt[m_ptr] = 1'b0;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
        if (req) m_err = 1'b1;
        if (!ld_en) m_load = 1'b0;
      end else if (pend_q.size() == 0) begin
        if (ld_en) begin
          m_load = 1'b1; m_ptr = 0;
        end else if (req) begin
          t.due  = cyc + WAIT_CYC + 1;
          t.w    = we;
          t.a    = int'(addr);
          t.d    = wdata;
          t.ok   = we || known[addr];
          t.perr = !we && corrupt[addr];
          pend_q.push_back(t);
          exp_q.push_back(we ? wdata : exp_mem[addr]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; req = 1'b0; ld_en = 1'b0; ld_valid = 1'b0;
    #1;
    chk("rst_now_ack", 32'(ack), 0);
    chk("rst_now_busy", 32'(busy), 0);
    chk("rst_now_err", 32'(err), 0);
    chk("rst_now_rdata", 32'(rdata), 0);
    chk("rst_now_ld_cnt", 32'(ld_cnt), 0);
    step();
    step();
    rst_ = 1'b1;
  endtask

  // One CPU transaction; returns rdata seen with ack. With noise, the captured
  // inputs and the load port are scrambled while the request is in flight.
  task automatic do_req(input bit w, input int a, input logic [DATA_W-1:0] d, input bit noise,
                        output logic [DATA_W-1:0] rd, output bit got);
    req = 1'b1; we = w; addr = ADDR_W'(a); wdata = d;
    step();
    req = 1'b0; got = 1'b0; rd = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ack) begin
        got = 1'b1; rd = rdata; ld_en = 1'b0; ld_valid = 1'b0;
      end else begin
        if (noise) begin
          addr = ADDR_W'($urandom); wdata = DATA_W'($urandom); we = 1'($urandom);
          ld_en = 1'($urandom); ld_valid = 1'($urandom); ld_data = DATA_W'($urandom);
        end
        step();
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack within 40 cycles for addr=%0d", a);
      ld_en = 1'b0; ld_valid = 1'b0;
    end
    step();
  endtask

  task automatic load_burst(input int n, input int req_odds);
    ld_en = 1'b1; ld_valid = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'($urandom); ld_data = DATA_W'($urandom);
      req = ($urandom_range(0, req_odds) == 0); addr = ADDR_W'($urandom);
      step();
    end
    req = 1'b0; ld_en = 1'b0; ld_valid = 1'($urandom); ld_data = DATA_W'($urandom);
    step();
    ld_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] rd;
    bit                got;
    int                op;
    #2;
    do_reset();

    // Read of addr 5 right after reset: ack only in cycle 3, busy cycles 1..3.
    req = 1'b1; we = 1'b0; addr = 5;
    step();
    req = 1'b0;
    chk("lat_c1_busy", 32'(busy), 1); chk("lat_c1_ack", 32'(ack), 0);
    step();
    chk("lat_c2_busy", 32'(busy), 1); chk("lat_c2_ack", 32'(ack), 0);
    step();
    chk("lat_c3_busy", 32'(busy), 1); chk("lat_c3_ack", 32'(ack), 1);
    step();
    chk("lat_c4_busy", 32'(busy), 0); chk("lat_c4_ack", 32'(ack), 0);

    // Load 0x00..0x1F then 0xAA: pointer wraps to 1, word 0 becomes 0xAA.
    ld_en = 1'b1; ld_valid = 1'b0;
    step();
    for (int i = 0; i < 33; i++) begin
      ld_valid = 1'b1;
      ld_data  = (i < 32) ? DATA_W'(i) : DATA_W'('hAA);
      step();
    end
    ld_valid = 1'b0;
    chk("load_wrap_ld_cnt", 32'(ld_cnt), 1);
    ld_en = 1'b0;
    step();
    do_req(1'b0, 0, '0, 1'b0, rd, got);
    chk("load_wrap_rd0", 32'(rd), 'hAA);

    // Write then read addr 31 with captured inputs scrambled during the wait.
    do_req(1'b1, 31, DATA_W'('hE3), 1'b1, rd, got);
    chk("sto_echo", 32'(rd), 'hE3);
    do_req(1'b0, 31, '0, 1'b1, rd, got);
    chk("sto_readback", 32'(rd), 'hE3);

    // CPU request while loading: dropped, err set and sticky.
    ld_en = 1'b1;
    step();
    req = 1'b1; we = 1'b1; addr = 2; wdata = DATA_W'('h77);
    step();
    req = 1'b0;
    chk("ldreq_err", 32'(err), 1);
    chk("ldreq_noack", 32'(ack), 0);
    ld_en = 1'b0;
    step();
    chk("ldreq_err_after_exit", 32'(err), 1);
    do_req(1'b0, 2, '0, 1'b0, rd, got);
    chk("ldreq_mem_unchanged", 32'(rd), 'h02);
    chk("ldreq_err_sticky", 32'(err), 1);

    // Reset in the middle of a write's wait states: no write happens.
    do_req(1'b1, 7, DATA_W'('h11), 1'b0, rd, got);
    req = 1'b1; we = 1'b1; addr = 7; wdata = DATA_W'('h55);
    step();
    req = 1'b0;
    do_reset();
    do_req(1'b0, 7, '0, 1'b0, rd, got);
    chk("abort_mem7", 32'(rd), 'h11);
    chk("abort_err_clear", 32'(err), 0);

    // Randomized mix of CPU transactions, load bursts and idle gaps.
    for (int k = 0; k < 160; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 6) begin
        do_req(1'($urandom), $urandom_range(0, DEPTH - 1), DATA_W'($urandom),
               1'($urandom), rd, got);
      end else if (op <= 8) begin
        load_burst($urandom_range(1, 40), 60);
      end else begin
        repeat ($urandom_range(1, 4)) step();
      end
    end

    do_reset();
`ifdef MEM_RESP_PARITY_EN
    do_req(1'b1, 3, DATA_W'('h5A), 1'b0, rd, got);
    dut.mem[3][DATA_W] = ~dut.mem[3][DATA_W];
    corrupt[3] = 1'b1;
    do_req(1'b0, 3, '0, 1'b0, rd, got);
    chk("parity_err_sticky", 32'(err), 1);
`else
    do_req(1'b1, 3, DATA_W'('h5A), 1'b0, rd, got);
    do_req(1'b0, 3, '0, 1'b0, rd, got);
    chk("noparity_rd3", 32'(rd), 'h5A);
    chk("noparity_err", 32'(err), 0);
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 8, data word width (matches CPU BIT_SIZE).
REQ-002 Parameter ADDR_W, default 5, address width (matches CPU BC_SIZE); depth = 2**ADDR_W words.
REQ-003 Parameter WAIT_CYC, default 2, wait states inserted before ack (range 0..15).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_  in  1  reset, asynchronous, active-low.
REQ-006 req  in  1  CPU memory request, sampled in IDLE only.
REQ-007 we  in  1  1 = write (STO), 0 = read (instruction/operand fetch).
REQ-008 addr  in  ADDR_W  CPU word address.
REQ-009 wdata  in  DATA_W  CPU write data.
REQ-010 rdata  out  DATA_W  read data, valid while ack=1.
REQ-011 ack  out  1  one-cycle completion pulse per accepted request.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 ld_en  in  1  host program-load mode request.
REQ-014 ld_valid  in  1  host load word valid.
REQ-015 ld_data  in  DATA_W  host load word.
REQ-016 ld_cnt  out  ADDR_W  next load address.
REQ-017 err  out  1  sticky; set by a CPU req while in LOAD.

Function
REQ-018 FSM states IDLE, WAIT, RESP, LOAD; storage is 2**ADDR_W x DATA_W registers.
REQ-019 IDLE: ld_en=1 -> LOAD, ld_cnt cleared to 0 (ld_en beats req); else req=1 -> capture addr/we/wdata, load wait counter with WAIT_CYC, -> WAIT (WAIT_CYC>0) or RESP (WAIT_CYC=0).
REQ-020 WAIT: counter decrements each cycle; at 1 -> RESP; req/addr/wdata changes ignored (captured values used).
REQ-021 RESP: ack=1 for exactly one cycle; write: mem[addr_q]<=wdata_q on this edge, rdata=wdata_q; read: rdata=mem[addr_q]; -> IDLE.
REQ-022 Latency req-sampled to ack = WAIT_CYC+1 cycles; back-to-back req accepted the cycle after ack (one IDLE cycle minimum).
REQ-023 rdata holds last value outside RESP.
REQ-024 LOAD: each cycle with ld_valid=1 writes mem[ld_cnt]<=ld_data, ld_cnt increments, wrapping 2**ADDR_W-1 -> 0.
REQ-025 LOAD: ld_en=0 -> IDLE next cycle; word with ld_valid=1 in that same cycle is still written.
REQ-026 LOAD: req=1 sets err, no ack generated, request discarded; err cleared only by reset.
REQ-027 ld_en rising while in WAIT/RESP is ignored until IDLE; in-flight request completes.

Reset
REQ-028 rst_ low asynchronously forces IDLE; ack=0, busy=0, err=0, rdata=0, ld_cnt=0, wait counter=0, captured request cleared.
REQ-029 Memory contents not reset; reset mid-WAIT aborts request with no ack and no write.
REQ-030 Reset deassertion synchronous in effect: first req sampled on first rising edge with rst_=1.

Configuration
REQ-031 Macro MEM_RESP_PARITY_EN: defined -> each word stores an extra even-parity bit computed on write (CPU and LOAD); read in RESP with parity mismatch sets err (sticky); output parity_err pulses with ack.
REQ-032 MEM_RESP_PARITY_EN undefined -> no parity storage, no parity_err port, err set only per REQ-026.

Verification
REQ-033 Reset, WAIT_CYC=2: req read addr 5 at cycle 0 -> ack high cycle 3 only, busy high cycles 1-3.
REQ-034 LOAD 32 words 0x00..0x1F then one more 0xAA -> ld_cnt wraps to 1, mem[0]=0xAA; read addr 0 -> rdata 0xAA.
REQ-035 Write 0xE3 to addr 31 (STO) then read addr 31 -> rdata 0xE3 on second ack; addr/wdata toggled during WAIT have no effect.
REQ-036 req during LOAD -> err=1, no ack, mem unchanged; stays 1 after LOAD exit until rst_ low.
REQ-037 rst_ low during WAIT of write to addr 7 (old 0x11) -> no ack, mem[7] still 0x11, outputs at reset values immediately.
REQ-038 MEM_RESP_PARITY_EN defined, force-flip stored bit of addr 3, read -> ack with parity_err=1, err=1; undefined build -> err stays 0.
